// File: rtl/ysyx_22050039_ifu_pkg.sv
// ysyx_22050039_ifu_pkg: shared IFU constants and FSM state encoding.
// The FAULT state exists only when YSYX_22050039_IFU_MISALIGN_CHECK_EN is defined.
package ysyx_22050039_ifu_pkg;
  localparam int IFU_XLEN = 64;
  localparam int IFU_INST_LEN = 32;
  localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] IFU_NOP = 32'h0000_0013;
`ifdef YSYX_22050039_IFU_MISALIGN_CHECK_EN
  typedef enum logic [2:0] {
    IFU_IDLE  = 3'd0,
    IFU_REQ   = 3'd1,
    IFU_WAIT  = 3'd2,
    IFU_HOLD  = 3'd3,
    IFU_DROP  = 3'd4,
    IFU_FAULT = 3'd5
  } ifu_state_e;
`else
  typedef enum logic [2:0] {
    IFU_IDLE = 3'd0,
    IFU_REQ  = 3'd1,
    IFU_WAIT = 3'd2,
    IFU_HOLD = 3'd3,
    IFU_DROP = 3'd4
  } ifu_state_e;
`endif
endpackage

// File: rtl/ysyx_22050039_ifu_pcgen.sv
// ysyx_22050039_ifu_pcgen: next-PC select (reset / redirect / pc+4 / hold) and alignment check.
// Macro YSYX_22050039_IFU_MISALIGN_CHECK_EN: report misaligned redirects instead of truncating them.
module ysyx_22050039_ifu_pcgen
  import ysyx_22050039_ifu_pkg::*;
#(
  parameter int XLEN = IFU_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
  input  logic            i_rst,
  input  logic            i_frozen,
  input  logic            i_advance,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic [XLEN-1:0] i_pc,
`ifdef YSYX_22050039_IFU_MISALIGN_CHECK_EN
  output logic            o_misalign,
`endif
  output logic [XLEN-1:0] o_pc_nxt
);
  logic            w_take;
  logic [XLEN-1:0] w_target;
`ifdef YSYX_22050039_IFU_MISALIGN_CHECK_EN
  assign o_misalign = i_redirect_valid && |i_redirect_pc[1:0];
  assign w_take = i_redirect_valid && !o_misalign && !i_frozen;
  assign w_target = i_redirect_pc;
`else
  assign w_take = i_redirect_valid && !i_frozen;
  assign w_target = i_redirect_pc & ~XLEN'(3);
`endif
  assign o_pc_nxt = i_rst ? RESET_PC : w_take ? w_target : i_advance ? i_pc + XLEN'(4) : i_pc;
endmodule

// File: rtl/ysyx_22050039_ifu.sv
// ysyx_22050039_ifu: single-outstanding instruction fetch unit feeding decode.
// Macro YSYX_22050039_IFU_MISALIGN_CHECK_EN adds the sticky fetch_fault trap on misaligned redirects.
module ysyx_22050039_ifu
  import ysyx_22050039_ifu_pkg::*;
#(
  parameter int XLEN = IFU_XLEN,
  parameter int INST_LEN = IFU_INST_LEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [XLEN-1:0]     imem_req_addr,
  input  logic                imem_resp_valid,
  input  logic [INST_LEN-1:0] imem_resp_data,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [INST_LEN-1:0] inst,
  output logic [XLEN-1:0]     pc,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc
`ifdef YSYX_22050039_IFU_MISALIGN_CHECK_EN
  ,
  output logic                fetch_fault
`endif
);
  ifu_state_e          r_state, w_state_nxt;
  logic [XLEN-1:0]     r_pc, w_pc_nxt;
  logic [INST_LEN-1:0] r_inst;
  logic                w_frozen, w_latch;
`ifdef YSYX_22050039_IFU_MISALIGN_CHECK_EN
  logic                w_misalign;
  assign w_frozen = r_state == IFU_FAULT;
  assign fetch_fault = w_frozen;
`else
  assign w_frozen = 1'b0;
`endif

  ysyx_22050039_ifu_pcgen #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pcgen (
    .i_rst            (rst),
    .i_frozen         (w_frozen),
    .i_advance        (r_state == IFU_HOLD && inst_ready),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .i_pc             (r_pc),
`ifdef YSYX_22050039_IFU_MISALIGN_CHECK_EN
    .o_misalign       (w_misalign),
`endif
    .o_pc_nxt         (w_pc_nxt)
  );

  // A redirect always wins; a response racing it belongs to the old path and is dropped.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IFU_IDLE: w_state_nxt = IFU_REQ;
      IFU_REQ:  w_state_nxt = imem_req_ready ? (redirect_valid ? IFU_DROP : IFU_WAIT) : IFU_REQ;
      IFU_WAIT: w_state_nxt = imem_resp_valid ? (redirect_valid ? IFU_REQ : IFU_HOLD)
                                              : (redirect_valid ? IFU_DROP : IFU_WAIT);
      IFU_HOLD: w_state_nxt = (redirect_valid || inst_ready) ? IFU_REQ : IFU_HOLD;
      IFU_DROP: w_state_nxt = imem_resp_valid ? IFU_REQ : IFU_DROP;
      default:  w_state_nxt = r_state;
    endcase
`ifdef YSYX_22050039_IFU_MISALIGN_CHECK_EN
    if (w_misalign && !w_frozen) w_state_nxt = IFU_FAULT;
`endif
  end

  assign w_latch = r_state == IFU_WAIT && imem_resp_valid && !redirect_valid;

  always_ff @(posedge clk) begin
    r_pc <= w_pc_nxt;
    if (rst) begin
      r_state <= IFU_IDLE;
      r_inst <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) r_inst <= imem_resp_data;
    end
  end

  assign imem_req_valid = r_state == IFU_REQ;
  assign imem_req_addr = r_pc;
  assign inst_valid = r_state == IFU_HOLD;
  assign inst = r_inst;
  assign pc = r_pc;
endmodule

// File: tb/tb_ysyx_22050039_ifu.sv
// tb_ysyx_22050039_ifu: scoreboard bench for the IFU with a behavioural instruction memory.
// Exercises the fault path when YSYX_22050039_IFU_MISALIGN_CHECK_EN is defined.
module tb_ysyx_22050039_ifu;
  localparam logic [63:0] A0 = 64'h8000_0000;
  logic        clk, rst;
  logic        imem_req_valid, imem_req_ready, imem_resp_valid;
  logic [63:0] imem_req_addr;
  logic [31:0] imem_resp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst;
  logic [63:0] pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
`ifdef YSYX_22050039_IFU_MISALIGN_CHECK_EN
  logic        fetch_fault;
`endif
  int          n_checks = 0, n_errors = 0;
  int          mem_lat, cyc;
  logic        poison;
  logic [63:0] exp_req[$];
  logic [63:0] exp_pc[$];
  logic [31:0] exp_word[$];

  ysyx_22050039_ifu dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .pc              (pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
`ifdef YSYX_22050039_IFU_MISALIGN_CHECK_EN
    ,
    .fetch_fault     (fetch_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h8000_0000: return 32'h0000_0413;
      64'h8000_0004: return 32'h0010_0073;
      default:       return a[31:0] ^ 32'h1357_0000;
    endcase
  endfunction

  task automatic push_inst(input logic [63:0] a);
    exp_pc.push_back(a);
    exp_word.push_back(mem_word(a));
  endtask

  task automatic await_valid(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!inst_valid && n < 20);
    if (!inst_valid) chk({tag, "_timeout"}, 0, 1);
    else if (exp_pc.size() == 0) chk({tag, "_no_expect"}, 1, 0);
    else begin
      chk({tag, "_pc"}, pc, exp_pc[0]);
      chk({tag, "_inst"}, inst, exp_word[0]);
    end
  endtask

  // Memory model and scoreboard: sampled just after the falling edge, once inputs are settled.
  initial begin
    logic        pend;
    int          cnt;
    logic [31:0] pend_data;
    pend = 1'b0;
    cnt = 0;
    pend_data = '0;
    imem_resp_valid = 1'b0;
    imem_resp_data = '0;
    forever begin
      @(negedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (rst) pend = 1'b0;
      else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data = pend_data;
          pend = 1'b0;
        end
      end
      if (!rst && imem_req_valid && imem_req_ready) begin
        if (exp_req.size() == 0) chk("req_unexpected", imem_req_addr, 0);
        else chk("req_addr", imem_req_addr, exp_req.pop_front());
        pend = 1'b1;
        cnt = mem_lat;
        pend_data = poison ? 32'hDEAD_BEEF : mem_word(imem_req_addr);
      end
      if (!rst && inst_valid && inst_ready) begin
        if (exp_pc.size() == 0) chk("inst_unexpected", {32'b0, inst}, 0);
        else begin
          chk("inst_pc", pc, exp_pc.pop_front());
          chk("inst_word", inst, exp_word.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b1;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    mem_lat = 1;
    poison = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_pc", pc, A0);
`ifdef YSYX_22050039_IFU_MISALIGN_CHECK_EN
    chk("rst_fault", fetch_fault, 0);
`endif
    exp_req.push_back(A0);
    push_inst(A0);
    rst = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!inst_valid && cyc < 20);
    chk("first_valid_cycle", cyc + 1, 4);
    chk("first_pc", pc, A0);
    chk("first_inst", inst, 32'h0000_0413);
    exp_req.push_back(A0 + 4);
    push_inst(A0 + 4);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    chk("second_req_addr", imem_req_addr, A0 + 4);
    await_valid("second");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_inst", inst, 32'h0010_0073);
      chk("stall_pc", pc, A0 + 4);
      chk("stall_no_req", imem_req_valid, 0);
      chk("stall_valid", inst_valid, 1);
    end
    exp_req.push_back(A0 + 8);
    push_inst(A0 + 8);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    chk("advance_addr", imem_req_addr, A0 + 8);
    await_valid("advance");
    exp_req.push_back(64'h8000_0100);
    push_inst(64'h8000_0100);
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0100;
    inst_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    chk("hold_redir_valid", imem_req_valid, 1);
    chk("hold_redir_addr", imem_req_addr, 64'h8000_0100);
    await_valid("hold_redir");
    mem_lat = 2;
    poison = 1'b1;
    exp_req.push_back(64'h8000_0104);
    exp_req.push_back(64'h8000_0200);
    push_inst(64'h8000_0200);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    @(negedge clk);
    poison = 1'b0;
    mem_lat = 1;
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0200;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("drop_no_valid", inst_valid, 0);
    chk("drop_no_req", imem_req_valid, 0);
    @(negedge clk);
    chk("wait_redir_valid", imem_req_valid, 1);
    chk("wait_redir_addr", imem_req_addr, 64'h8000_0200);
    await_valid("wait_redir");
    exp_req.push_back(64'h8000_0204);
    exp_req.push_back(64'h8000_0300);
    push_inst(64'h8000_0300);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0300;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("resp_redir_valid", imem_req_valid, 1);
    chk("resp_redir_addr", imem_req_addr, 64'h8000_0300);
    chk("resp_redir_no_inst", inst_valid, 0);
    await_valid("resp_redir");
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0102;
    inst_ready = 1'b1;
`ifdef YSYX_22050039_IFU_MISALIGN_CHECK_EN
    @(negedge clk);
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("fault_sticky", fetch_fault, 1);
      chk("fault_no_req", imem_req_valid, 0);
      chk("fault_no_inst", inst_valid, 0);
      redirect_valid = i == 2;
      redirect_pc = 64'h8000_0400;
      @(negedge clk);
    end
    redirect_valid = 1'b0;
`else
    exp_req.push_back(64'h8000_0100);
    push_inst(64'h8000_0100);
    @(negedge clk);
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    chk("misalign_addr", imem_req_addr, 64'h8000_0100);
    await_valid("misalign");
`endif
    rst = 1'b1;
    exp_pc.delete();
    exp_word.delete();
    @(negedge clk);
    chk("rerst_pc", pc, A0);
    chk("rerst_inst_valid", inst_valid, 0);
    chk("rerst_req_valid", imem_req_valid, 0);
`ifdef YSYX_22050039_IFU_MISALIGN_CHECK_EN
    chk("rerst_fault", fetch_fault, 0);
`endif
    exp_req.push_back(A0);
    push_inst(A0);
    rst = 1'b0;
    await_valid("restart");
    chk("req_queue_empty", exp_req.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
